ahb3lite_sim_console: RTL and testbench

Parametrised, multi-channel successor to the single-address simulation printf slave on the AHB3-Lite interconnect. It exposes `CHANNELS` independent byte TX channels, each with a `DEPTH`-entry FIFO, status, control and drop-counter registers. Each channel is drained through a valid/ready byte port to the Verilator harness or a UART model. A per-channel mode selects back-pressure (HREADYOUT wait states) or drop-on-full.

---
 rtl/ahb3lite_sim_console.sv | 179 +++++++++++++++++
 tb/tb_ahb3lite_sim_console.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sim_console.sv
// ahb3lite_sim_console
//   Multi-channel AHB3-Lite simulation console. Each of CHANNELS channels owns
//   a DEPTH-entry byte TX FIFO plus STATUS, CTRL and DROPCNT registers, and is
//   drained through its own valid/ready byte port.
//   Register offsets (HADDR[3:2]): 0 TXDATA (WO), 1 STATUS (RO),
//   2 CTRL (RW: bit0 enable, bit1 block), 3 DROPCNT (RO, write clears).
//   Channel index is HADDR[CB+3:4]; an index >= CHANNELS answers with a
//   two-cycle ERROR response.
// Ports
//   HCLK, HRESETn              clock, synchronous active-low reset
//   HSEL .. HRESP              AHB3-Lite slave port (HSIZE/HBURST/HPROT ignored)
//   out_valid/out_data/ready   per-channel byte stream, channel c at [8c+7:8c]
module ahb3lite_sim_console #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 16,
  parameter bit RESET_BLOCK = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [CHANNELS-1:0]   out_valid,
  output logic [8*CHANNELS-1:0] out_data,
  input  logic [CHANNELS-1:0]   out_ready
);
  localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // ST_XFER covers both a zero-wait data phase and a blocked TXDATA stall;
  // the stall is decided combinationally from the current full flag.
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ERR1, ST_ERR2} state_t;
  state_t r_state, w_state_nxt;

  logic          r_write;
  logic [CB-1:0] r_chan;
  logic [1:0]    r_off;

  logic [7:0]          r_mem   [CHANNELS][DEPTH];
  logic [AW-1:0]       r_wp    [CHANNELS];
  logic [AW-1:0]       r_rp    [CHANNELS];
  logic [LW-1:0]       r_level [CHANNELS];
  logic [15:0]         r_drop  [CHANNELS];
  logic [CHANNELS-1:0] r_en, r_blk;

  logic [CB-1:0]       w_chan;
  logic                w_chan_err, w_accept, w_done, w_addr_ld, w_stall;
  logic [CHANNELS-1:0] w_full, w_empty, w_hit, w_push, w_pop, w_drop;
  logic [CHANNELS-1:0] w_hold, w_ctrl_wr, w_drop_clr;
  logic [31:0]         w_rd32;
  logic                w_unused;

  assign w_unused   = &{1'b0, HSIZE, HBURST, HPROT, HTRANS[0], HADDR, HWDATA};
  assign w_chan     = HADDR[CB+3:4];
  assign w_chan_err = (int'(w_chan) >= CHANNELS);
  assign w_accept   = HSEL & HREADY & HTRANS[1];
  assign w_addr_ld  = w_done & w_accept;
  assign out_valid  = r_en & ~w_empty;
  assign w_pop      = out_valid & out_ready;

  // Per-channel data-phase decode. Full is taken from the registered level,
  // i.e. before any pop in the same cycle.
  always_comb begin
    w_full     = '0;
    w_empty    = '0;
    w_hit      = '0;
    w_push     = '0;
    w_drop     = '0;
    w_hold     = '0;
    w_ctrl_wr  = '0;
    w_drop_clr = '0;
    out_data   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_full[c]     = (r_level[c] == LW'(DEPTH));
      w_empty[c]    = (r_level[c] == '0);
      w_hit[c]      = (r_state == ST_XFER) && r_write && (r_chan == CB'(c));
      w_push[c]     = w_hit[c] && (r_off == 2'd0) && !w_full[c];
      w_drop[c]     = w_hit[c] && (r_off == 2'd0) && w_full[c] && !r_blk[c];
      w_hold[c]     = w_hit[c] && (r_off == 2'd0) && w_full[c] && r_blk[c];
      w_ctrl_wr[c]  = w_hit[c] && (r_off == 2'd2);
      w_drop_clr[c] = w_hit[c] && (r_off == 2'd3);
      out_data[8*c +: 8] = r_mem[c][r_rp[c]];
    end
  end

  assign w_stall = |w_hold;

  always_comb begin
    w_rd32 = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (r_chan == CB'(c)) begin
        case (r_off)
          2'd1:    w_rd32 = {8'h00, 8'(r_level[c]), 14'h0, w_full[c], w_empty[c]};
          2'd2:    w_rd32 = {30'h0, r_blk[c], r_en[c]};
          2'd3:    w_rd32 = {16'h0, r_drop[c]};
          default: w_rd32 = '0;
        endcase
      end
    end
    HRDATA = '0;
    if (r_state == ST_XFER && !r_write) HRDATA[31:0] = w_rd32;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      ST_XFER: w_done = !w_stall;
      ST_ERR1: begin
        w_done      = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
    if (w_done) begin
      if (w_accept) w_state_nxt = w_chan_err ? ST_ERR1 : ST_XFER;
      else          w_state_nxt = ST_IDLE;
    end
    HREADYOUT = w_done;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_chan  <= '0;
      r_off   <= '0;
      r_en    <= '1;
      r_blk   <= {CHANNELS{RESET_BLOCK}};
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_wp[c]    <= '0;
        r_rp[c]    <= '0;
        r_level[c] <= '0;
        r_drop[c]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_addr_ld) begin
        r_write <= HWRITE;
        r_chan  <= w_chan;
        r_off   <= HADDR[3:2];
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (w_push[c]) r_wp[c] <= r_wp[c] + AW'(1);
        if (w_pop[c])  r_rp[c] <= r_rp[c] + AW'(1);
        if (w_push[c] && !w_pop[c])      r_level[c] <= r_level[c] + LW'(1);
        else if (!w_push[c] && w_pop[c]) r_level[c] <= r_level[c] - LW'(1);
        if (w_ctrl_wr[c]) begin
          r_en[c]  <= HWDATA[0];
          r_blk[c] <= HWDATA[1];
        end
        if (w_drop_clr[c])                              r_drop[c] <= '0;
        else if (w_drop[c] && (r_drop[c] != 16'hFFFF)) r_drop[c] <= r_drop[c] + 16'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_push[c]) r_mem[c][r_wp[c]] <= HWDATA[7:0];
    end
  end

endmodule

// File: tb/tb_ahb3lite_sim_console.sv
// tb_ahb3lite_sim_console
//   Scoreboard bench: stimulus queues expected bus responses and drained
//   bytes; two monitors compare what the DUT presents. Three channels are
//   instantiated so that channel index 3 lies outside the implemented range.
module tb_ahb3lite_sim_console;
  localparam int CH    = 3;
  localparam int DEPTH = 16;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL    = 1'b0;
  logic [31:0]   HADDR   = '0;
  logic [31:0]   HWDATA  = '0;
  logic [31:0]   HRDATA;
  logic          HWRITE  = 1'b0;
  logic [2:0]    HSIZE   = 3'b010;
  logic [2:0]    HBURST  = '0;
  logic [3:0]    HPROT   = '0;
  logic [1:0]    HTRANS  = '0;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [CH-1:0]   out_valid;
  logic [8*CH-1:0] out_data;
  logic [CH-1:0]   out_ready = '0;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb3lite_sim_console #(
    .HADDR_SIZE (32),
    .HDATA_SIZE (32),
    .CHANNELS   (CH),
    .DEPTH      (DEPTH),
    .RESET_BLOCK(1'b0)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  typedef struct {
    int          id;
    logic        is_rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] bq0[$];
  logic [7:0] bq1[$];
  logic [7:0] bq2[$];
  int n_checks = 0;
  int n_errors = 0;
  int bus_id   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] A(input int c, input int o);
    return 32'(c * 16 + o * 4);
  endfunction

  task automatic push_byte(input int c, input logic [7:0] b);
    case (c)
      0:       bq0.push_back(b);
      1:       bq1.push_back(b);
      default: bq2.push_back(b);
    endcase
  endtask

  task automatic pop_byte(input int c, output logic ok, output logic [7:0] b);
    ok = 1'b0;
    b  = '0;
    case (c)
      0: if (bq0.size() > 0) begin ok = 1'b1; b = bq0.pop_front(); end
      1: if (bq1.size() > 0) begin ok = 1'b1; b = bq1.pop_front(); end
      default: if (bq2.size() > 0) begin ok = 1'b1; b = bq2.pop_front(); end
    endcase
  endtask

  // One transfer: address phase, then data phase held until HREADYOUT.
  task automatic bus_xfer(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rexp, input logic resp, input int waits);
    bus_exp_t e;
    int n;
    e.id    = bus_id;
    e.is_rd = !is_wr;
    e.data  = rexp;
    e.resp  = resp;
    e.waits = waits;
    bus_id++;
    bus_q.push_back(e);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = addr; HWRITE = is_wr; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    n = 0;
    while (!HREADYOUT && n < 64) begin
      @(posedge HCLK); #1;
      n++;
    end
    if (!HREADYOUT) begin
      n_checks++;
      n_errors++;
      $display("FAIL bus%0d_timeout: actual HREADYOUT=0 required 1 within 64 cycles", e.id);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_xfer(1'b1, addr, data, '0, 1'b0, 0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_xfer(1'b0, addr, '0, exp, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  initial begin : bus_mon
    logic dp;
    int w;
    bus_exp_t e;
    dp = 1'b0;
    w  = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 1'b0;
        w  = 0;
      end else begin
        if (dp && !HREADYOUT) begin
          w++;
          if (w == 1 && bus_q.size() > 0 && bus_q[0].resp)
            chk($sformatf("bus%0d_err1_hresp", bus_q[0].id), {31'b0, HRESP}, 32'd1);
        end else if (dp) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL bus_unexpected: actual completed transfer required none");
          end else begin
            e = bus_q.pop_front();
            chk($sformatf("bus%0d_hresp", e.id), {31'b0, HRESP}, {31'b0, e.resp});
            chk($sformatf("bus%0d_waits", e.id), w, e.waits);
            if (e.is_rd && !e.resp) chk($sformatf("bus%0d_hrdata", e.id), HRDATA, e.data);
          end
          dp = 1'b0;
        end
        if (HREADYOUT) begin
          dp = HSEL && HTRANS[1];
          w  = 0;
        end
      end
    end
  end

  initial begin : byte_mon
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        for (int c = 0; c < CH; c++) begin
          if (out_valid[c] && out_ready[c]) begin
            pop_byte(c, ok, b);
            if (!ok) begin
              n_checks++;
              n_errors++;
              $display("FAIL ch%0d_byte_unexpected: actual 0x%02h required none", c, out_data[8*c +: 8]);
            end else begin
              chk($sformatf("ch%0d_byte", c), {24'b0, out_data[8*c +: 8]}, {24'b0, b});
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_out_valid", {29'b0, out_valid}, 32'd0);
    HRESETn = 1'b1;

    // ch0 streaming with consumer always ready
    out_ready = 3'b001;
    push_byte(0, 8'h41);
    wr(A(0, 0), 32'h41);
    @(posedge HCLK); #1;
    chk("ch0_first_valid", {31'b0, out_valid[0]}, 32'd1);
    chk("ch0_first_data", {24'b0, out_data[7:0]}, 32'h41);
    push_byte(0, 8'h42);
    wr(A(0, 0), 32'h42);
    push_byte(0, 8'h43);
    wr(A(0, 0), 32'h43);
    idle(4);
    rd(A(0, 1), 32'h1);
    rd(A(0, 2), 32'h1);

    // ch1 drop-on-full: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) begin
      if (i < 16) push_byte(1, 8'(8'h60 + i));
      wr(A(1, 0), 32'(8'h60 + i));
    end
    rd(A(1, 1), 32'h0010_0002);
    rd(A(1, 3), 32'd4);
    wr(A(1, 3), 32'hDEAD);
    rd(A(1, 3), 32'd0);
    out_ready[1] = 1'b1;
    idle(24);
    rd(A(1, 1), 32'h1);

    // ch0 blocking: 17th write stalls until one byte is popped
    out_ready[0] = 1'b0;
    wr(A(0, 2), 32'h3);
    rd(A(0, 2), 32'h3);
    for (int i = 0; i < 16; i++) begin
      push_byte(0, 8'(8'h80 + i));
      wr(A(0, 0), 32'(8'h80 + i));
    end
    push_byte(0, 8'h90);
    fork
      bus_xfer(1'b1, A(0, 0), 32'h90, '0, 1'b0, 2);
      begin
        repeat (3) @(posedge HCLK);
        #1 out_ready[0] = 1'b1;
        @(posedge HCLK);
        #1 out_ready[0] = 1'b0;
      end
    join
    rd(A(0, 1), 32'h0010_0002);
    rd(A(0, 3), 32'd0);
    out_ready[0] = 1'b1;
    idle(24);
    rd(A(0, 1), 32'h1);
    wr(A(0, 2), 32'h1);

    // out-of-range channel: two-cycle ERROR, nothing changes
    bus_xfer(1'b0, A(3, 1), '0, '0, 1'b1, 1);
    bus_xfer(1'b1, A(3, 0), 32'h55, '0, 1'b1, 1);
    bus_xfer(1'b1, A(3, 2), 32'h0, '0, 1'b1, 1);
    rd(A(0, 1), 32'h1);
    rd(A(1, 1), 32'h1);
    rd(A(2, 1), 32'h1);
    rd(A(0, 2), 32'h1);
    rd(A(2, 2), 32'h1);
    rd(A(1, 3), 32'd0);

    // ch2 disabled: bytes retained, then drained in order
    out_ready[2] = 1'b1;
    wr(A(2, 2), 32'h0);
    for (int i = 0; i < 5; i++) begin
      push_byte(2, 8'(8'hA0 + i));
      wr(A(2, 0), 32'(8'hA0 + i));
    end
    idle(2);
    #1;
    chk("ch2_disabled_valid", {31'b0, out_valid[2]}, 32'd0);
    rd(A(2, 1), 32'h0005_0000);
    wr(A(2, 2), 32'h1);
    idle(12);
    rd(A(2, 1), 32'h1);

    // reset during a stall
    out_ready = 3'b000;
    for (int i = 0; i < 17; i++) wr(A(1, 0), 32'(8'hB0 + i));
    rd(A(1, 3), 32'd1);
    wr(A(0, 2), 32'h3);
    for (int i = 0; i < 16; i++) wr(A(0, 0), 32'(8'hC0 + i));
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = A(0, 0); HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hEE;
    chk("stall_hreadyout_a", {31'b0, HREADYOUT}, 32'd0);
    @(posedge HCLK); #1;
    chk("stall_hreadyout_b", {31'b0, HREADYOUT}, 32'd0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk("rst2_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst2_hresp", {31'b0, HRESP}, 32'd0);
    chk("rst2_out_valid", {29'b0, out_valid}, 32'd0);
    HRESETn = 1'b1;
    out_ready = 3'b111;
    rd(A(0, 1), 32'h1);
    rd(A(1, 1), 32'h1);
    rd(A(1, 3), 32'd0);
    rd(A(0, 2), 32'h1);
    idle(4);

    chk("bus_queue_left", bus_q.size(), 32'd0);
    chk("ch0_queue_left", bq0.size(), 32'd0);
    chk("ch1_queue_left", bq1.size(), 32'd0);
    chk("ch2_queue_left", bq2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
